// File: rtl/rv32i_mc_ctrl_pkg.sv
// Shared types for the RV32I multi-cycle control slice: opcode map, ALU codes,
// controller state, datapath mux selects and the per-instruction control word.
// Also provides the helper that flags reserved funct3 codes per opcode.
package rv32i_mc_ctrl_pkg;

  typedef logic [2:0] funct3_t;
  typedef logic [6:0] funct7_t;

  typedef enum logic [6:0] {
    OPC_LOAD     = 7'b0000011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_OP_IMM   = 7'b0010011,
    OPC_AUIPC    = 7'b0010111,
    OPC_STORE    = 7'b0100011,
    OPC_OP       = 7'b0110011,
    OPC_LUI      = 7'b0110111,
    OPC_BRANCH   = 7'b1100011,
    OPC_JALR     = 7'b1100111,
    OPC_JAL      = 7'b1101111,
    OPC_SYSTEM   = 7'b1110011
  } rv32i_opcode_t;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SR   = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_fn_t;

  // Memory size code used for instruction fetch
  localparam funct3_t MEM_SIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } ctrl_state_t;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,
    PC_REL   = 2'd1,
    PC_ALU   = 2'd2
  } pc_sel_t;

  typedef enum logic [1:0] {
    ALU_A_RS1  = 2'd0,
    ALU_A_PC   = 2'd1,
    ALU_A_ZERO = 2'd2
  } alu_a_sel_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MDR = 2'd1,
    WB_PC  = 2'd2
  } wb_sel_t;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_type_t;

  typedef struct packed {
    alu_a_sel_t alu_a_sel;
    logic       alu_b_sel;
    alu_fn_t    alu_fn;
    logic       alu_alt;
    imm_type_t  imm_type;
    wb_sel_t    wb_sel;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jal;
    logic       is_jalr;
    logic       is_fence;
  } ctrl_word_t;

  // Reserved funct3 codes for opcodes whose funct3 selects size/condition
  function automatic logic funct3_illegal(input logic [6:0] opc, input funct3_t f3);
    logic bad;
    bad = 1'b0;
    case (opc)
      OPC_LOAD:   bad = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      OPC_STORE:  bad = (f3 > 3'b010);
      OPC_BRANCH: bad = (f3[2:1] == 2'b01);
      OPC_JALR:   bad = (f3 != 3'b000);
      default:    bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/rv32i_decode.sv
// Combinational instruction decoder: IR word -> control word plus illegal flag.
// Zero latency; pure function of instr, no handshake.
// Register indices are ignored here; the datapath reads them straight from IR.
module rv32i_decode
  import rv32i_mc_ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  output ctrl_word_t  cw_o,
  output logic        illegal_o
);

  logic [6:0] opcode;
  funct3_t    f3;
  funct7_t    f7;
  logic       unused_fields;

  assign opcode        = instr_i[6:0];
  assign f3            = instr_i[14:12];
  assign f7            = instr_i[31:25];
  assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

  // Per-opcode operand selects, writeback source and legality
  always_comb begin
    cw_o      = '0;
    illegal_o = 1'b0;
    case (opcode)
      OPC_OP: begin
        cw_o.alu_fn  = alu_fn_t'(f3);
        cw_o.alu_alt = f7[5];
        if (!((f7 == 7'b0000000) ||
              ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)))))
          illegal_o = 1'b1;
      end
      OPC_OP_IMM: begin
        cw_o.alu_b_sel = 1'b1;
        cw_o.alu_fn    = alu_fn_t'(f3);
        cw_o.imm_type  = IMM_I;
        if (f3 == 3'b001) begin
          if (f7 != 7'b0000000) illegal_o = 1'b1;
        end else if (f3 == 3'b101) begin
          cw_o.alu_alt = f7[5];
          if ((f7 != 7'b0000000) && (f7 != 7'b0100000)) illegal_o = 1'b1;
        end
      end
      OPC_LOAD: begin
        cw_o.alu_b_sel = 1'b1;
        cw_o.imm_type  = IMM_I;
        cw_o.wb_sel    = WB_MDR;
        cw_o.is_load   = 1'b1;
      end
      OPC_STORE: begin
        cw_o.alu_b_sel = 1'b1;
        cw_o.imm_type  = IMM_S;
        cw_o.is_store  = 1'b1;
      end
      OPC_LUI: begin
        cw_o.alu_a_sel = ALU_A_ZERO;
        cw_o.alu_b_sel = 1'b1;
        cw_o.imm_type  = IMM_U;
      end
      OPC_AUIPC: begin
        cw_o.alu_a_sel = ALU_A_PC;
        cw_o.alu_b_sel = 1'b1;
        cw_o.imm_type  = IMM_U;
      end
      OPC_BRANCH: begin
        cw_o.imm_type  = IMM_B;
        cw_o.is_branch = 1'b1;
      end
      OPC_JAL: begin
        cw_o.imm_type = IMM_J;
        cw_o.wb_sel   = WB_PC;
        cw_o.is_jal   = 1'b1;
      end
      OPC_JALR: begin
        cw_o.alu_b_sel = 1'b1;
        cw_o.imm_type  = IMM_I;
        cw_o.wb_sel    = WB_PC;
        cw_o.is_jalr   = 1'b1;
      end
      OPC_MISC_MEM: cw_o.is_fence = 1'b1;
      // SYSTEM has no CSR support, so it lands here with unknown opcodes
      default: illegal_o = 1'b1;
    endcase
    if ((instr_i[1:0] != 2'b11) || funct3_illegal(opcode, f3))
      illegal_o = 1'b1;
  end

endmodule

// File: rtl/rv32i_mc_ctrl.sv
// RV32I multi-cycle controller: FETCH/DECODE/EXEC/MEM/WB(/TRAP) sequencing.
// Latency per instruction 2..5 cycles with zero-wait memory; mem_req held until mem_ready.
// RV_ILLEGAL_TRAP_EN: defined -> sticky TRAP on illegal; undefined -> trap pulse + NOP.
module rv32i_mc_ctrl
  import rv32i_mc_ctrl_pkg::*;
#(
  parameter int RESET_STATE_FETCH = 1
)(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        branch_cond,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [2:0]  mem_size,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [1:0]  alu_a_sel,
  output logic        alu_b_sel,
  output logic [2:0]  alu_fn,
  output logic        alu_alt,
  output logic [2:0]  imm_type,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state,
  output logic        trap
);

  // Only 1 is supported today; other values park the FSM in the halted state
  localparam ctrl_state_t RST_STATE = (RESET_STATE_FETCH == 1) ? ST_FETCH : ST_TRAP;

`ifdef RV_ILLEGAL_TRAP_EN
  localparam ctrl_state_t ILLEGAL_NEXT = ST_TRAP;
`else
  localparam ctrl_state_t ILLEGAL_NEXT = ST_FETCH;
`endif

  ctrl_word_t  cw;
  logic        illegal;
  ctrl_state_t state_q, state_d;

  rv32i_decode u_decode (
    .instr_i   (instr),
    .cw_o      (cw),
    .illegal_o (illegal)
  );

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        if (illegal)          state_d = ILLEGAL_NEXT;
        else if (cw.is_fence) state_d = ST_FETCH;
        else                  state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (cw.is_load || cw.is_store) state_d = ST_MEM;
        else if (cw.is_branch)         state_d = ST_FETCH;
        else                           state_d = ST_WB;
      end
      ST_MEM:    if (mem_ready) state_d = cw.is_load ? ST_WB : ST_FETCH;
      ST_WB:     state_d = ST_FETCH;
`ifdef RV_ILLEGAL_TRAP_EN
      ST_TRAP:   state_d = ST_TRAP;
`else
      ST_TRAP:   state_d = ST_FETCH;
`endif
      default:   state_d = ST_FETCH;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) state_q <= RST_STATE;
    else     state_q <= state_d;
  end

  // Reset masks the debug view so everything reads zero while rst is high
  assign state = rst ? ST_FETCH : state_q;

  // Datapath controls decoded from state and IR; all forced low during reset
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_size     = 3'b000;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_PLUS4;
    alu_a_sel    = ALU_A_RS1;
    alu_b_sel    = 1'b0;
    alu_fn       = ALU_ADD;
    alu_alt      = 1'b0;
    imm_type     = IMM_I;
    rf_we        = 1'b0;
    wb_sel       = WB_ALU;
    trap         = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          mem_req  = 1'b1;
          mem_size = MEM_SIZE_WORD;
          if (mem_ready) begin
            ir_we = 1'b1;
            pc_we = 1'b1;
          end
        end
        ST_DECODE: trap = illegal;
        ST_EXEC: begin
          alu_a_sel = cw.alu_a_sel;
          alu_b_sel = cw.alu_b_sel;
          alu_fn    = cw.alu_fn;
          alu_alt   = cw.alu_alt;
          imm_type  = cw.imm_type;
          if (cw.is_branch) begin
            pc_we  = branch_cond;
            pc_sel = PC_REL;
          end
        end
        ST_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_size     = instr[14:12];
          mem_we       = cw.is_store;
        end
        ST_WB: begin
          rf_we    = 1'b1;
          wb_sel   = cw.wb_sel;
          imm_type = cw.imm_type;
          if (cw.is_jal) begin
            pc_we  = 1'b1;
            pc_sel = PC_REL;
          end else if (cw.is_jalr) begin
            pc_we  = 1'b1;
            pc_sel = PC_ALU;
          end
        end
        ST_TRAP: trap = 1'b1;
        default: trap = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
module tb_rv32i_mc_ctrl;
  import rv32i_mc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        branch_cond, mem_ready;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, alu_b_sel, alu_alt, rf_we, trap;
  logic [2:0]  mem_size, alu_fn, imm_type, state;
  logic [1:0]  pc_sel, alu_a_sel, wb_sel;
  logic [26:0] all_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  rv32i_mc_ctrl #(.RESET_STATE_FETCH(1)) dut (
    .clk(clk), .rst(rst), .instr(instr), .branch_cond(branch_cond), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr_sel(mem_addr_sel),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .alu_fn(alu_fn), .alu_alt(alu_alt), .imm_type(imm_type), .rf_we(rf_we), .wb_sel(wb_sel),
    .state(state), .trap(trap)
  );

  assign all_o = {mem_req, mem_we, mem_size, mem_addr_sel, ir_we, pc_we, pc_sel, alu_a_sel,
                  alu_b_sel, alu_fn, alu_alt, imm_type, rf_we, wb_sel, state, trap};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #2;
    cyc++;
  endtask

  // Complete a zero-wait fetch of w; leaves the DUT in DECODE
  task automatic do_fetch(input logic [31:0] w);
    instr = w;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; instr = 32'h0; branch_cond = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (all_o !== 27'd0) begin
        bad++; $display("FAIL reset_outputs cycle %0d got=%h want=0", i, all_o);
      end
    end
    rst = 1'b0;
    #1;
    total++;
    if ({state, mem_req, mem_size} !== {ST_FETCH, 1'b1, 3'b010}) begin
      bad++; $display("FAIL reset_release got state=%0d req=%b size=%b want 0/1/010", state, mem_req, mem_size);
    end
  endtask

  task automatic test_add;
    int t0;
    t0 = cyc;
    instr = 32'h002081B3; mem_ready = 1'b1;
    #1;
    total++;
    if ({mem_req, ir_we, pc_we, pc_sel} !== 5'b11100) begin
      bad++; $display("FAIL add_fetch got=%b want=11100", {mem_req, ir_we, pc_we, pc_sel});
    end
    tick(); mem_ready = 1'b0;
    total++;
    if ({state, trap} !== {ST_DECODE, 1'b0}) begin
      bad++; $display("FAIL add_decode got state=%0d trap=%b want 1/0", state, trap);
    end
    tick();
    total++;
    if ({state, alu_a_sel, alu_b_sel, alu_fn, alu_alt} !== {ST_EXEC, 2'd0, 1'b0, 3'b000, 1'b0}) begin
      bad++; $display("FAIL add_exec got st=%0d a=%0d b=%b fn=%b alt=%b", state, alu_a_sel, alu_b_sel, alu_fn, alu_alt);
    end
    tick();
    total++;
    if ({state, rf_we, wb_sel, pc_we} !== {ST_WB, 1'b1, 2'd0, 1'b0}) begin
      bad++; $display("FAIL add_wb got st=%0d rf_we=%b wb=%0d pc_we=%b", state, rf_we, wb_sel, pc_we);
    end
    tick();
    total++;
    if (state !== ST_FETCH || (cyc - t0) != 4) begin
      bad++; $display("FAIL add_latency got st=%0d cycles=%0d want 0/4", state, cyc - t0);
    end
  endtask

  task automatic test_sub;
    do_fetch(32'h402081B3);
    tick();
    total++;
    if ({alu_fn, alu_alt, alu_b_sel} !== {3'b000, 1'b1, 1'b0}) begin
      bad++; $display("FAIL sub_exec got fn=%b alt=%b b=%b want 000/1/0", alu_fn, alu_alt, alu_b_sel);
    end
    tick();
    tick();
  endtask

  task automatic test_load_wait;
    int t0;
    t0 = cyc;
    do_fetch(32'h0080A283);
    tick();
    total++;
    if ({state, alu_b_sel, alu_fn, imm_type} !== {ST_EXEC, 1'b1, 3'b000, 3'd0}) begin
      bad++; $display("FAIL lw_exec got st=%0d b=%b fn=%b imm=%0d", state, alu_b_sel, alu_fn, imm_type);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({state, mem_req, mem_we, mem_size, mem_addr_sel} !== {ST_MEM, 1'b1, 1'b0, 3'b010, 1'b1}) begin
        bad++; $display("FAIL lw_mem_wait%0d got st=%0d req=%b we=%b size=%b asel=%b", i, state, mem_req, mem_we, mem_size, mem_addr_sel);
      end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    total++;
    if ({state, mem_req} !== {ST_MEM, 1'b1}) begin
      bad++; $display("FAIL lw_mem_done got st=%0d req=%b want 3/1", state, mem_req);
    end
    tick(); mem_ready = 1'b0;
    total++;
    if ({state, rf_we, wb_sel} !== {ST_WB, 1'b1, 2'd1}) begin
      bad++; $display("FAIL lw_wb got st=%0d rf_we=%b wb=%0d want 4/1/1", state, rf_we, wb_sel);
    end
    tick();
    total++;
    if (state !== ST_FETCH || (cyc - t0) != 8) begin
      bad++; $display("FAIL lw_latency got st=%0d cycles=%0d want 0/8", state, cyc - t0);
    end
  endtask

  task automatic test_store;
    int t0;
    t0 = cyc;
    do_fetch(32'h0020A223);
    tick();
    total++;
    if (imm_type !== 3'd1) begin
      bad++; $display("FAIL sw_exec_imm got=%0d want=1", imm_type);
    end
    tick();
    mem_ready = 1'b1;
    #1;
    total++;
    if ({state, mem_req, mem_we, mem_size, mem_addr_sel} !== {ST_MEM, 1'b1, 1'b1, 3'b010, 1'b1}) begin
      bad++; $display("FAIL sw_mem got st=%0d req=%b we=%b size=%b asel=%b", state, mem_req, mem_we, mem_size, mem_addr_sel);
    end
    tick(); mem_ready = 1'b0;
    total++;
    if (state !== ST_FETCH || rf_we !== 1'b0 || (cyc - t0) != 4) begin
      bad++; $display("FAIL sw_latency got st=%0d rf_we=%b cycles=%0d want 0/0/4", state, rf_we, cyc - t0);
    end
  endtask

  task automatic test_branch;
    for (int k = 0; k < 2; k++) begin
      int   t0;
      logic exp_we;
      exp_we = (k == 0);
      t0 = cyc;
      branch_cond = exp_we;
      do_fetch(32'h00208463);
      tick();
      total++;
      if ({state, pc_we, pc_sel, imm_type} !== {ST_EXEC, exp_we, 2'd1, 3'd2}) begin
        bad++; $display("FAIL beq_exec%0d got st=%0d pc_we=%b pc_sel=%0d imm=%0d want we=%b", k, state, pc_we, pc_sel, imm_type, exp_we);
      end
      tick();
      total++;
      if (state !== ST_FETCH || (cyc - t0) != 3) begin
        bad++; $display("FAIL beq_latency%0d got st=%0d cycles=%0d want 0/3", k, state, cyc - t0);
      end
    end
    branch_cond = 1'b0;
  endtask

  task automatic test_jalr;
    int t0;
    t0 = cyc;
    do_fetch(32'h000100E7);
    tick();
    total++;
    if ({alu_b_sel, alu_fn, imm_type} !== {1'b1, 3'b000, 3'd0}) begin
      bad++; $display("FAIL jalr_exec got b=%b fn=%b imm=%0d", alu_b_sel, alu_fn, imm_type);
    end
    tick();
    total++;
    if ({rf_we, wb_sel, pc_we, pc_sel} !== {1'b1, 2'd2, 1'b1, 2'd2}) begin
      bad++; $display("FAIL jalr_wb got rf_we=%b wb=%0d pc_we=%b pc_sel=%0d want 1/2/1/2", rf_we, wb_sel, pc_we, pc_sel);
    end
    tick();
    total++;
    if (state !== ST_FETCH || (cyc - t0) != 4) begin
      bad++; $display("FAIL jalr_latency got st=%0d cycles=%0d want 0/4", state, cyc - t0);
    end
  endtask

  task automatic test_lui;
    do_fetch(32'h123450B7);
    tick();
    total++;
    if ({alu_a_sel, alu_b_sel, alu_fn, imm_type} !== {2'd2, 1'b1, 3'b000, 3'd3}) begin
      bad++; $display("FAIL lui_exec got a=%0d b=%b fn=%b imm=%0d want 2/1/000/3", alu_a_sel, alu_b_sel, alu_fn, imm_type);
    end
    tick();
    tick();
  endtask

  task automatic test_fence;
    int t0;
    t0 = cyc;
    do_fetch(32'h0000000F);
    total++;
    if ({state, trap} !== {ST_DECODE, 1'b0}) begin
      bad++; $display("FAIL fence_decode got st=%0d trap=%b want 1/0", state, trap);
    end
    tick();
    total++;
    if (state !== ST_FETCH || (cyc - t0) != 2) begin
      bad++; $display("FAIL fence_latency got st=%0d cycles=%0d want 0/2", state, cyc - t0);
    end
  endtask

  task automatic test_illegal;
    logic [31:0] ill [4];
    ill[0] = 32'h00000073;
    ill[1] = 32'h402091B3;
    ill[2] = 32'h0080B283;
    ill[3] = 32'h00000000;
    for (int k = 0; k < 4; k++) begin
      do_fetch(ill[k]);
      total++;
      if ({state, trap, rf_we, pc_we, mem_req} !== {ST_DECODE, 1'b1, 1'b0, 1'b0, 1'b0}) begin
        bad++; $display("FAIL illegal%0d_decode got st=%0d trap=%b rf=%b pc=%b req=%b", k, state, trap, rf_we, pc_we, mem_req);
      end
      tick();
`ifdef RV_ILLEGAL_TRAP_EN
      for (int i = 0; i < 12; i++) begin
        total++;
        if ({state, trap, mem_req, pc_we, rf_we, ir_we} !== {ST_TRAP, 1'b1, 4'b0000}) begin
          bad++; $display("FAIL illegal%0d_sticky%0d got st=%0d trap=%b req=%b pc=%b rf=%b", k, i, state, trap, mem_req, pc_we, rf_we);
        end
        tick();
      end
      do_reset();
`else
      total++;
      if ({state, trap, mem_req} !== {ST_FETCH, 1'b0, 1'b1}) begin
        bad++; $display("FAIL illegal%0d_resume got st=%0d trap=%b req=%b want 0/0/1", k, state, trap, mem_req);
      end
`endif
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] prog [3];
    int          lat  [3];
    prog[0] = 32'h002081B3; lat[0] = 4;
    prog[1] = 32'h0020A223; lat[1] = 4;
    prog[2] = 32'h00208463; lat[2] = 3;
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int n;
      n = 0;
      instr = prog[k];
      do begin
        tick();
        n++;
      end while (state !== ST_FETCH && n < 20);
      total++;
      if (n != lat[k]) begin
        bad++; $display("FAIL b2b%0d_latency got=%0d want=%0d", k, n, lat[k]);
      end
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset_midreq;
    #1;
    total++;
    if (mem_req !== 1'b1) begin
      bad++; $display("FAIL midreq_pending got req=%b want 1", mem_req);
    end
    rst = 1'b1;
    #1;
    total++;
    if (mem_req !== 1'b0) begin
      bad++; $display("FAIL midreq_drop got req=%b want 0", mem_req);
    end
    tick();
    rst = 1'b0;
    #1;
    total++;
    if ({state, mem_req} !== {ST_FETCH, 1'b1}) begin
      bad++; $display("FAIL midreq_restart got st=%0d req=%b want 0/1", state, mem_req);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_load_wait();
    test_store();
    test_branch();
    test_jalr();
    test_lui();
    test_fence();
    test_illegal();
    test_back_to_back();
    test_reset_midreq();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv32i_mc_ctrl.md
Name: rv32i_mc_ctrl

Overview:
Multi-cycle control unit for the RV32I core. It sequences the shared datapath (PC, IR, register file, ALU, single memory port) through fetch/decode/execute/memory/writeback using the base opcode map, ALU function codes and load/store size codes from the shared packages. The block holds only state; the datapath holds IR, old_pc, ALU-out and MDR registers.

Parameters:
RESET_STATE_FETCH, 1, must be 1; reserved for a later debug-halt start state.

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
instr  in  32  IR contents (valid from DECODE onward)
branch_cond  in  1  datapath comparator result for instr funct3; sampled in EXEC
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request; held until mem_ready
mem_we  out  1  store when mem_req=1
mem_size  out  3  load/store funct3 code; WORD on fetch
mem_addr_sel  out  1  0=PC, 1=ALU-out
ir_we  out  1  latch instr and old_pc
pc_we  out  1  PC write enable
pc_sel  out  2  0=PC+4, 1=old_pc+imm, 2=ALU-out&~1
alu_a_sel  out  2  0=rs1, 1=old_pc, 2=zero
alu_b_sel  out  1  0=rs2, 1=imm
alu_fn  out  3  alu_fn_t
alu_alt  out  1  SUB/SRA select (funct7 bit 30)
imm_type  out  3  I,S,B,U,J
rf_we  out  1  register-file write
wb_sel  out  2  0=ALU-out, 1=MDR, 2=PC
state  out  3  current state, for debug
trap  out  1  illegal-instruction flag

Behaviour:
- clk is the only clock; rst is synchronous and active-high. While rst=1, every output is 0 and state is FETCH. rst mid-request drops mem_req; memory tolerates abandoned requests.
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Outputs decode from state and instr; no output depends on mem_ready except ir_we/pc_we in FETCH and the MEM exit.
- FETCH: mem_req=1, mem_addr_sel=0, mem_size=WORD. When mem_ready=1: ir_we=1, pc_we=1, pc_sel=0, go to DECODE. Otherwise stay, holding all outputs stable.
- DECODE: register read. If illegal, go to TRAP. MISC_MEM (FENCE) is a NOP and goes to FETCH. Otherwise go to EXEC.
- EXEC by opcode:
  - OP: a=rs1, b=rs2, fn=funct3, alt=funct7[5]; go to WB.
  - OP_IMM: b=imm(I); alt=funct7[5] only for funct3=101, else 0; go to WB.
  - LOAD/STORE: ADD rs1+imm(I/S); go to MEM.
  - LUI: a=zero, b=imm(U), ADD; AUIPC: a=old_pc; both go to WB.
  - BRANCH: pc_we=branch_cond, pc_sel=1, imm=B; go to FETCH.
  - JAL: imm=J; go to WB.
  - JALR: ADD rs1+imm(I); go to WB.
- MEM: mem_req=1, mem_addr_sel=1, mem_size=funct3, mem_we=1 for STORE. On mem_ready, LOAD goes to WB (MDR latched) and STORE goes to FETCH.
- WB: rf_we=1. wb_sel=MDR for LOAD, PC for JAL/JALR, else ALU-out. JAL adds pc_we=1 with pc_sel=1; JALR adds pc_we=1 with pc_sel=2. Then go to FETCH.
- rd=x0 writes are still issued; the register file discards them.
- Minimum latencies with zero-wait memory:
  - ALU/LUI/AUIPC/JAL/JALR: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
  - FENCE: 2 cycles.
- Illegal conditions:
  - instr[1:0]≠11
  - opcode not in rv32i_opcode_t
  - SYSTEM (no CSR support)
  - load funct3 ∈ {011,110,111}
  - store funct3 > 010
  - branch funct3 ∈ {010,011}
  - JALR funct3≠000
  - OP funct7 ∉ {0000000,0100000}, or 0100000 with funct3 ∉ {000,101}
  - shift-immediate funct7 invalid
- mem_req never drops without mem_ready except on rst.

Optional Feature:
RV_ILLEGAL_TRAP_EN.
- Defined: illegal instructions enter TRAP. TRAP is sticky until rst: trap=1, no memory, PC or RF activity.
- Undefined: illegal instructions go DECODE→FETCH as NOPs (PC already +4). trap pulses high for the DECODE cycle only; the TRAP state is unreachable.

Decomposition:
- Shared package (alongside the opcode packages):
  - ctrl_state_t
  - pc_sel_t
  - alu_a_sel_t
  - wb_sel_t
  - imm_type_t
  - an illegal-funct3 helper function
- Reuse rv32i_opcode_t, alu_fn_t, funct7_t and funct3_t as they are.
- One combinational sub-module, rv32i_decode: instr → control word plus illegal flag. The FSM sits in rv32i_mc_ctrl.

Test Plan:
- rst=1 for 2 cycles, then release → all outputs 0 during reset; mem_req=1 with mem_size=WORD on the first cycle after release.
- ADD x3,x1,x2 (0x002081B3) with mem_ready tied 1 → 4 cycles. EXEC: fn=000, alt=0. WB: rf_we=1, wb_sel=0.
- LW x5,8(x1) (0x0080A283) with mem_ready delayed 3 cycles in MEM → mem_req stays 1 with mem_size=010 for all 3 wait cycles; WB wb_sel=1; total 8 cycles.
- BEQ (0x00208463) with branch_cond=1, then again with branch_cond=0 → EXEC pc_we=1 with pc_sel=1 when taken; pc_we=0 when not taken; back to FETCH after 3 cycles.
- JALR x1,0(x2) (0x000100E7) → WB has rf_we=1, wb_sel=2, pc_we=1 and pc_sel=2 in the same cycle.
- Illegal 0x00000073 (ECALL) → with RV_ILLEGAL_TRAP_EN: state=TRAP, trap held 1 for 10+ cycles until rst. Without it: trap pulses 1 cycle and fetch resumes.
